// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding, counter sizing and parameter checks for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;
  function automatic int cnt_w(input int burst);
    return $clog2(burst) + 1;
  endfunction
  function automatic bit params_ok(input int nreq, input int burst);
    return nreq >= 2 && burst >= 1;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search starting just above last_owner
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_owner,
  output logic                    any,
  output logic [$clog2(NREQ)-1:0] sel
);
  localparam int OW = $clog2(NREQ);
  logic [OW-1:0] idx;
  // walk from lowest to highest priority so the nearest requester overwrites
  always_comb begin
    any = |req;
    sel = '0;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = OW'((int'(last_owner) + k) % NREQ);
      sel = req[idx] ? idx : sel;
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write-port sharing for an async FIFO with a per-grant burst cap
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int Width = 4,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                    wclk,
  input  logic                    wreset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*Width-1:0]   req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         gnt,
  output logic [Width-1:0]        fifo_wdata,
  output logic                    fifo_wen,
  input  logic                    fifo_full,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] owner
);
  localparam int OW = $clog2(NREQ);
  localparam int CW = cnt_w(BURST);
  if (!params_ok(NREQ, BURST)) begin : g_bad_params
    $error("fifo_wr_arbiter: NREQ must be >= 2 and BURST >= 1");
  end
  arb_state_t    state;
  logic [OW-1:0] last_owner;
  logic [CW-1:0] beat_cnt;
  logic          pick_any;
  logic [OW-1:0] pick_sel;
  logic          beat;
  logic          done;
  logic [Width-1:0] slice;
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req        (req),
    .last_owner (last_owner),
    .any        (pick_any),
    .sel        (pick_sel)
  );
  always_comb begin
    slice = '0;
    for (int i = 0; i < NREQ; i++)
      slice = (owner == OW'(i)) ? req_data[i*Width +: Width] : slice;
  end
  // fifo_full acts in the same cycle; a dropped req ends ownership even while stalled
  always_comb begin
    busy       = state == ARB_OWN;
    beat       = busy && req[owner] && !fifo_full;
    gnt        = beat ? NREQ'(1) << owner : '0;
    fifo_wen   = beat;
    fifo_wdata = busy ? slice : '0;
    done       = !req[owner] || (beat && (req_last[owner] || beat_cnt == CW'(BURST - 1)));
  end
  always_ff @(posedge wclk) begin
    if (wreset) begin
      state      <= ARB_IDLE;
      owner      <= '0;
      last_owner <= OW'(NREQ - 1);
      beat_cnt   <= '0;
    end else if (state == ARB_IDLE) begin
      if (pick_any) begin
        owner    <= pick_sel;
        beat_cnt <= '0;
        state    <= ARB_OWN;
      end
    end else if (done) begin
      state      <= ARB_IDLE;
      last_owner <= owner;
    end else if (beat) begin
      beat_cnt <= beat_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios plus random traffic checked against an ownership model
module tb_fifo_wr_arbiter;
  logic        wclk = 1'b0;
  logic        wreset;
  logic [3:0]  req, req_last, gnt;
  logic [15:0] req_data;
  logic [3:0]  fifo_wdata;
  logic        fifo_wen, fifo_full, busy;
  logic [1:0]  owner;
  int checks = 0;
  int errors = 0;
  bit m_busy;
  int m_owner, m_last, m_beats;
  logic [3:0] obs_gnt, obs_wdata;
  logic       obs_busy;
  logic [1:0] obs_owner;

  fifo_wr_arbiter #(.Width(4), .NREQ(4), .BURST(4)) dut (
    .wclk       (wclk),
    .wreset     (wreset),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .gnt        (gnt),
    .fifo_wdata (fifo_wdata),
    .fifo_wen   (fifo_wen),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .owner      (owner)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = 3;
    m_beats = 0;
  endtask

  // one clock cycle: drive, compare against the model, then advance the model across the edge
  task automatic step(input logic [3:0] r, input logic [15:0] d, input logic [3:0] l,
                      input logic f, input logic rs);
    bit bt;
    logic [3:0] ew;
    @(negedge wclk);
    req = r; req_data = d; req_last = l; fifo_full = f; wreset = rs;
    #1;
    bt = m_busy && r[m_owner] && !f;
    ew = m_busy ? d[m_owner*4 +: 4] : 4'h0;
    chk("gnt", gnt, bt ? (32'd1 << m_owner) : 32'd0);
    chk("wen", fifo_wen, bt);
    chk("wdata", fifo_wdata, ew);
    chk("busy", busy, m_busy);
    chk("owner", owner, m_owner);
    obs_gnt = gnt; obs_wdata = fifo_wdata; obs_busy = busy; obs_owner = owner;
    if (rs) model_reset();
    else if (!m_busy) begin
      if (r != 0) begin
        for (int k = 4; k >= 1; k--) if (r[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
        m_busy  = 1'b1;
        m_beats = 0;
      end
    end else if (!r[m_owner] || (bt && (l[m_owner] || m_beats == 3))) begin
      m_busy = 1'b0;
      m_last = m_owner;
    end else if (bt) m_beats++;
  endtask

  initial begin
    wreset = 1'b1; req = 0; req_data = 0; req_last = 0; fifo_full = 0;
    @(posedge wclk);
    model_reset();
    // reset held with everyone requesting
    step(4'hF, 16'h1234, 0, 0, 1);
    step(4'hF, 16'h1234, 0, 0, 1);
    step(4'hF, 16'h1234, 0, 0, 0);
    chk("rst_idle_gnt", obs_gnt, 0);
    // round-robin: 4 beats then a bubble per owner
    for (int c = 0; c < 20; c++) begin
      step(4'hF, 16'($urandom), 0, 0, 0);
      chk("rr", obs_gnt, (c % 5 == 4) ? 0 : (32'd1 << (c / 5)));
    end
    // packet end on requester 1
    step(0, 0, 0, 0, 1);
    step(4'h2, 0, 0, 0, 0);
    step(4'h2, 16'h00A0, 0, 0, 0);
    chk("pkt_a", obs_wdata, 4'hA);
    step(4'h2, 16'h00B0, 4'h2, 0, 0);
    chk("pkt_b", obs_wdata, 4'hB);
    step(4'h2, 16'h00C0, 0, 0, 0);
    chk("pkt_idle", obs_busy, 0);
    step(4'h2, 16'h00C0, 0, 0, 0);
    chk("pkt_regain", obs_gnt, 4'h2);
    // full stall on owner 2
    step(0, 0, 0, 0, 1);
    step(4'h4, 16'h0500, 0, 0, 0);
    step(4'h4, 16'h0500, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      step(4'h4, 16'h0600, 0, 1, 0);
      chk("stall_gnt", obs_gnt, 0);
      chk("stall_owner", obs_owner, 2);
    end
    for (int c = 0; c < 3; c++) begin
      step(4'h4, 16'h0700, 0, 0, 0);
      chk("stall_resume", obs_gnt, 4'h4);
    end
    step(4'h4, 16'h0800, 0, 0, 0);
    chk("stall_release", obs_busy, 0);
    // withdraw by owner 0 while requester 3 waits
    step(0, 0, 0, 0, 1);
    step(4'h9, 16'h9009, 0, 0, 0);
    step(4'h9, 16'h9009, 0, 0, 0);
    step(4'h8, 16'h9009, 0, 0, 0);
    chk("wd_nobeat", obs_gnt, 0);
    step(4'h8, 16'h9009, 0, 0, 0);
    chk("wd_bubble", obs_busy, 0);
    step(4'h8, 16'h9009, 0, 0, 0);
    chk("wd_owner3", obs_gnt, 4'h8);
    for (int c = 0; c < 12; c++) step(4'hF, 16'($urandom), 0, 0, 0);
    // reset during beat 2 of owner 1
    step(0, 0, 0, 0, 1);
    step(4'h2, 16'h0030, 0, 0, 0);
    step(4'h2, 16'h0030, 0, 0, 0);
    step(4'h2, 16'h0040, 0, 0, 1);
    chk("mid_rst_beat", obs_gnt, 4'h2);
    step(4'hF, 16'h4321, 0, 0, 0);
    chk("mid_rst_busy", obs_busy, 0);
    chk("mid_rst_owner", obs_owner, 0);
    step(4'hF, 16'h4321, 0, 0, 0);
    chk("mid_rst_first", obs_gnt, 4'h1);
    // random traffic
    for (int c = 0; c < 400; c++)
      step(4'($urandom), 16'($urandom), 4'($urandom & $urandom), ($urandom % 4) == 0,
           ($urandom % 64) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
